// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - decode-to-issue valid/ready FIFO with occupancy and whole-queue flush
module decode_issue_queue #(
    parameter int PAYLOAD_W   = 97,
    parameter int DEPTH       = 2,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int PASSTHROUGH = 0,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 snoop_hit,
    input  logic                 bco_valid,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [CW-1:0]        o_count,
    output logic                 o_afull
);

    generate
        if (PASSTHROUGH != 0) begin : g_pt
            // Wire-through build: no storage, so clock, reset and flush have nothing to act on.
            logic unused_pt;
            assign unused_pt = ^{clk, resetn, snoop_hit, bco_valid};

            assign o_valid   = i_valid;
            assign o_payload = i_payload;
            assign i_ready   = o_ready;
            assign o_count   = '0;
            assign o_afull   = 1'b0;
        end else begin : g_fifo
            localparam int AW = $clog2(DEPTH);
            localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
            localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

            logic [PAYLOAD_W-1:0] mem_q [DEPTH];
            logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
            logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]        count_q, count_d;
            logic                 flush, push, pop;

            // i_ready looks only at registered occupancy, so a full queue refuses input even while popping.
            assign i_ready = (count_q != FULL_C);
            assign o_valid = (count_q != '0);
            assign flush   = snoop_hit | bco_valid;
            assign push    = i_valid & i_ready & ~flush;
            assign pop     = o_valid & o_ready & ~flush;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
                    if (push && !pop)      count_d = count_q + CW'(1);
                    else if (pop && !push) count_d = count_q - CW'(1);
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Payload storage is deliberately left unreset; only pointers and count define validity.
            always_ff @(posedge clk) begin
                if (push) mem_q[wr_ptr_q] <= i_payload;
            end

            assign o_payload = mem_q[rd_ptr_q];
            assign o_count   = count_q;
            assign o_afull   = (count_q >= AFULL_C);
        end
    endgenerate

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised decode-to-issue buffer: a DEPTH-entry valid/ready FIFO that carries one packed decoded instruction (PC, ROB tag, immediate, FID, class flags, pipe selects, per-pipe commands) per entry. It sits between the decode stage and the issue stage and replaces the single-register decode issue stage. It adds backpressure, multi-entry buffering, occupancy reporting and whole-queue flush on snoop hit or branch-commit override.

## Interface
Parameters:
- PAYLOAD_W, 97: packed issue payload width; decode packs {pc[31:0], rob[3:0], imm[25:0], fid[7:0], branch, load, store, pipe_alu, pipe_mul, pipe_mem, pipe_bru, alu_cmd[4:0], mul_cmd[0:0], mem_cmd[4:0], bru_cmd[6:0], bagu_cmd[1:0]}, MSB first.
- DEPTH, 2: number of entries; power of two, at least 2.
- AFULL_LEVEL, DEPTH-1: occupancy at or above which o_afull is asserted; range 1..DEPTH.
- PASSTHROUGH, 0: 1 builds a zero-latency wire-through with no storage.

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- snoop_hit  in  1  flush request from snoop.
- bco_valid  in  1  flush request from branch-commit override.
- i_valid  in  1  decode offers an entry.
- i_ready  out  1  queue can accept an entry.
- i_payload  in  PAYLOAD_W  entry from decode.
- o_valid  out  1  head entry is valid.
- o_ready  in  1  issue consumes the head entry.
- o_payload  out  PAYLOAD_W  head entry.
- o_count  out  CW  current occupancy, 0..DEPTH.
- o_afull  out  1  o_count >= AFULL_LEVEL.

## Operation
- flush = snoop_hit | bco_valid.
- push = i_valid & i_ready & ~flush.
- pop = o_valid & o_ready & ~flush.
- Storage is a circular buffer with a write pointer and a read pointer, each $clog2(DEPTH) bits wide, plus a count register of CW bits. The pointers wrap modulo DEPTH by natural overflow.
- Push: write i_payload at the write pointer, then increment the write pointer.
- Pop: increment the read pointer.
- Count: +1 on push only, -1 on pop only, unchanged when both push and pop occur.
- i_ready = (count != DEPTH). It depends only on registered state and never on o_ready. A full queue therefore refuses input even in a cycle where it pops.
- o_valid = (count != 0).
- o_payload = entry at the read pointer. It is undefined while o_valid is 0.
- o_count = count. o_afull is derived combinationally from count.
- Flush has priority over push and pop. On the next edge, count and both pointers go to 0. The input offered in the flush cycle is discarded, and the head is not consumed.
- Storage entries are not reset or cleared; only the pointers and count are.
- PASSTHROUGH=1:
  - o_valid = i_valid, o_payload = i_payload, i_ready = o_ready.
  - o_count = 0, o_afull = 0.
  - No flush gating and no state.

## Timing
- Reset: while resetn is low, regardless of clk, count = 0 and both pointers = 0. Outputs during reset: o_valid = 0, i_ready = 1, o_count = 0, o_afull = 0 (unless AFULL_LEVEL requires otherwise; the parameter range excludes that).
- Pushes are impossible while in reset. The first push is taken on the first rising edge after resetn deasserts.
- Latency: an entry pushed at edge N is visible on o_valid/o_payload after edge N. Issue can therefore consume it in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle, sustained whenever 0 < count < DEPTH.
- Full (count = DEPTH): i_ready = 0. A pop at edge N makes i_ready = 1 after edge N.
- Empty (count = 0): o_valid = 0, and o_ready is ignored. There is no combinational bypass from input to output.
- Handshake: decode holds i_valid and i_payload until it sees i_ready. The queue holds o_payload stable while o_valid=1 and o_ready=0, unless a flush occurs.
- Flush with push and pop in the same cycle: count becomes 0. o_valid = 0 and i_ready = 1 after the edge.
- Reset asserted mid-stream: all entries are lost immediately.

## Test plan
- Reset then fill, DEPTH=2: push A, then B, with o_ready=0. Required: o_count = 1, then 2. i_ready = 0 after the second edge. o_payload = A throughout.
- Drain order: from full {A, B}, hold o_ready=1 for 2 cycles. Required: A then B on o_payload, count 2→1→0, o_valid = 0 after the second edge.
- Streaming, DEPTH=4: i_valid=o_ready=1 for 20 cycles with incrementing payloads. Required: count stays at 1, payloads exit in order one cycle after entry, pointers wrap correctly (check across 5 wraps).
- Flush: with count=3, assert bco_valid in the same cycle as i_valid and o_ready. Required: count = 0 and o_valid = 0 next cycle, the offered payload is never output, and o_afull (AFULL_LEVEL=3) deasserts. Repeat the scenario using snoop_hit.
- Full and popping: count = DEPTH, i_valid=1, o_ready=1. Required: i_ready = 0 in that cycle, count = DEPTH-1 after the edge, then the push is accepted the next cycle.
- Async reset mid-stream: drop resetn between clock edges while count = 2. Required: o_valid = 0 and o_count = 0 immediately, without waiting for clk. PASSTHROUGH=1 build: outputs follow inputs combinationally, and o_count = 0.
